// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, oversampled by the rx_en tick.
// Define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3 vote around the decision tick.
module uart_rx #(
   parameter int OVERSAMPLING = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_en,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int CW  = $clog2(OVERSAMPLING);
   localparam int MID = OVERSAMPLING / 2;
   localparam logic [CW-1:0] START_D = CW'(MID - 1);
   localparam logic [CW-1:0] LAST_D  = CW'(OVERSAMPLING - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER
   } state_t;

   state_t          state_q;
   logic            sync1_q;
   logic            sync2_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic [7:0]      data_q;
   logic            valid_q;
   logic            ferr_q;
   logic            busy_q;

   logic            rxd_s;
   logic [CW-1:0]   dec_pt;
   logic            at_dec;
   logic            sample_bit;

   assign rxd_s = sync2_q;

   always_comb begin
      dec_pt = (state_q == S_START) ? START_D : LAST_D;
      at_dec = (cnt_q == dec_pt);
   end

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] smp_q;
   logic [2:0] smp_d;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // Samples at D-2, D-1 land in the register; the D sample is used live.
   always_comb begin
      smp_d = smp_q;
      if (cnt_q == dec_pt - CW'(2))
         smp_d[0] = rxd_s;
      else if (cnt_q == dec_pt - CW'(1))
         smp_d[1] = rxd_s;
      else if (cnt_q == dec_pt)
         smp_d[2] = rxd_s;
   end

   assign sample_bit = maj3(smp_d);
`else
   assign sample_bit = rxd_s;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         smp_q   <= '0;
`endif
      end else begin
         sync1_q <= RxD;
         sync2_q <= sync1_q;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (rx_en) begin
            unique case (state_q)
               S_IDLE: begin
                  if (!rxd_s) begin
                     cnt_q   <= '0;
                     state_q <= S_START;
                     busy_q  <= 1'b1;
                  end
               end
               S_START: begin
                  if (at_dec) begin
                     cnt_q <= '0;
                     if (!sample_bit) begin
                        bit_q   <= '0;
                        state_q <= S_DATA;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_DATA: begin
                  if (at_dec) begin
                     shift_q <= {sample_bit, shift_q[7:1]};
                     cnt_q   <= '0;
                     bit_q   <= bit_q + 3'd1;
                     if (bit_q == 3'd7)
                        state_q <= S_STOP;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_STOP: begin
                  if (at_dec) begin
                     cnt_q  <= '0;
                     busy_q <= 1'b0;
                     if (sample_bit) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= S_RECOVER;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_RECOVER: begin
                  // Wait out a break so a held-low line reports only once.
                  if (rxd_s)
                     state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
`ifdef UART_RX_MAJORITY_EN
            if (state_q == S_IDLE || at_dec)
               smp_q <= '0;
            else if (state_q == S_START || state_q == S_DATA || state_q == S_STOP)
               smp_q <= smp_d;
`endif
         end
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = busy_q;

endmodule
